// File: rtl/lsu_align_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types, funct3 encodings and helper functions for the
//            lsu_align load/store front end.
// Contents : lsu_state_t  - split-access sequencer state
//            F3_*         - RISC-V load/store funct3 encodings
//            is_misaligned, nbytes, load_extend
// Revision : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halfwords need an even address; anything with funct3[1] set is a word
    // (including the unused codes 011/110/111) and needs a 4-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a != 2'b00));
    endfunction

    function automatic logic [2:0] nbytes(input logic [2:0] f3);
        if (f3[1])      return 3'd4;
        else if (f3[0]) return 3'd2;
        else            return 3'd1;
    endfunction

    // funct3[2] selects zero extension (lbu/lhu), otherwise sign extension.
    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] f3);
        if (f3[1])
            return raw;
        else if (f3[0])
            return f3[2] ? {16'h0000, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
        else
            return f3[2] ? {24'h000000, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align_if
// Purpose  : Bundles the MEM-stage request/response signals and the data RAM
//            port handled by lsu_align.
// Ports    : req_*        - request from the MEM stage
//            stall/rdata/misalign_err - response to the pipeline
//            ram_*        - byte/half/word RAM port (combinational read)
// Modports : slave  - the lsu_align side
//            master - pipeline + RAM side
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_align_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              stall;
    logic [31:0]       rdata;
    logic              misalign_err;
    logic              ram_we;
    logic [2:0]        ram_mode;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
        output stall, rdata, misalign_err, ram_we, ram_mode, ram_addr, ram_din
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
        input  stall, rdata, misalign_err, ram_we, ram_mode, ram_addr, ram_din
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Load/store front end between the MEM stage and the data RAM.
//            Aligned accesses pass straight through in the same cycle.
//            Misaligned half/word accesses are split into byte accesses in
//            ascending address order while the pipeline is stalled; loads are
//            reassembled little-endian and sign/zero extended.
// Ports    : clk  - clock
//            rst  - synchronous active-high reset
//            bus  - lsu_align_if.slave (request, response and RAM port)
// Params   : ADDR_W           - byte address width
//            ALLOW_MISALIGNED - 1: split misaligned accesses,
//                               0: suppress them and pulse misalign_err
// Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
#(
    parameter int ADDR_W           = 12,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    lsu_align_if.slave     bus
);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    lsu_state_t        r_state;
    logic [1:0]        r_idx;
    logic [23:0]       r_lbuf;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_f3;
    logic              r_we;
    logic [31:0]       r_wdata;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    lsu_state_t        w_next_state;
    logic [1:0]        w_next_idx;
    logic [23:0]       w_next_lbuf;
    logic              w_capture;
    logic              w_req_mis;
    logic              w_last;
    logic [7:0]        w_wbyte;
    logic [31:0]       w_raw;

    logic              w_stall;
    logic [31:0]       w_rdata;
    logic              w_misalign_err;
    logic              w_ram_we;
    logic [2:0]        w_ram_mode;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [31:0]       w_ram_din;

    assign w_req_mis = is_misaligned(bus.req_funct3, bus.req_addr[1:0]);
    assign w_last    = ({1'b0, r_idx} == (nbytes(r_f3) - 3'd1));
    assign w_wbyte   = r_wdata[{r_idx, 3'b000} +: 8];

    // Final byte arrives combinationally from the RAM; earlier bytes are
    // held in the load buffer.
    assign w_raw = r_f3[1] ? {bus.ram_dout[7:0], r_lbuf}
                           : {16'h0000, bus.ram_dout[7:0], r_lbuf[7:0]};

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_lbuf  <= 24'h000000;
            r_addr  <= '0;
            r_f3    <= 3'b000;
            r_we    <= 1'b0;
            r_wdata <= 32'h0000_0000;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
            r_lbuf  <= w_next_lbuf;
            if (w_capture) begin
                r_addr  <= bus.req_addr;
                r_f3    <= bus.req_funct3;
                r_we    <= bus.req_we;
                r_wdata <= bus.req_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state   = r_state;
        w_next_idx     = r_idx;
        w_next_lbuf    = r_lbuf;
        w_capture      = 1'b0;
        w_stall        = 1'b0;
        w_rdata        = 32'h0000_0000;
        w_misalign_err = 1'b0;
        w_ram_we       = 1'b0;
        w_ram_mode     = bus.req_funct3;
        w_ram_addr     = bus.req_addr;
        w_ram_din      = bus.req_wdata;

        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (!w_req_mis) begin
                        w_ram_we = bus.req_we;
                        w_rdata  = bus.req_we ? 32'h0000_0000 : bus.ram_dout;
                    end else if (ALLOW_MISALIGNED) begin
                        // Byte 0 goes out in the request cycle itself.
                        w_capture    = 1'b1;
                        w_ram_we     = bus.req_we;
                        w_ram_mode   = bus.req_we ? F3_B : F3_BU;
                        w_ram_din    = {24'h000000, bus.req_wdata[7:0]};
                        w_stall      = 1'b1;
                        w_next_lbuf  = {r_lbuf[23:8], bus.ram_dout[7:0]};
                        w_next_idx   = 2'd1;
                        w_next_state = S_BUSY;
                    end else begin
                        w_misalign_err = 1'b1;
                    end
                end
            end

            S_BUSY: begin
                // Request inputs are ignored here; only captured values drive
                // the RAM. Address wraps naturally at ADDR_W bits.
                w_ram_we   = r_we;
                w_ram_mode = r_we ? F3_B : F3_BU;
                w_ram_addr = r_addr + ADDR_W'(r_idx);
                w_ram_din  = {24'h000000, w_wbyte};
                if (!w_last) begin
                    w_stall = 1'b1;
                    case (r_idx)
                        2'd1:    w_next_lbuf[15:8]  = bus.ram_dout[7:0];
                        2'd2:    w_next_lbuf[23:16] = bus.ram_dout[7:0];
                        default: w_next_lbuf[7:0]   = bus.ram_dout[7:0];
                    endcase
                    w_next_idx = r_idx + 2'd1;
                end else begin
                    w_rdata      = r_we ? 32'h0000_0000 : load_extend(w_raw, r_f3);
                    w_next_idx   = 2'd0;
                    w_next_state = S_IDLE;
                end
            end

            default: begin
                w_next_state = S_IDLE;
                w_next_idx   = 2'd0;
            end
        endcase

        // An access interrupted by reset must not commit the byte that is
        // on the bus during the reset cycle.
        if (rst) begin
            w_ram_we       = 1'b0;
            w_misalign_err = 1'b0;
        end
    end

    assign bus.stall        = w_stall;
    assign bus.rdata        = w_rdata;
    assign bus.misalign_err = w_misalign_err;
    assign bus.ram_we       = w_ram_we;
    assign bus.ram_mode     = w_ram_mode;
    assign bus.ram_addr     = w_ram_addr;
    assign bus.ram_din      = w_ram_din;

endmodule
`default_nettype wire

// File: tb/tb_lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_align
// Purpose  : Directed self-checking bench for lsu_align. Two instances: one
//            splitting misaligned accesses, one flagging them as errors.
//            Each has its own byte-array RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_align;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    lsu_align_if #(.ADDR_W(12)) bus0 ();
    lsu_align_if #(.ADDR_W(12)) bus1 ();

    lsu_align #(.ADDR_W(12), .ALLOW_MISALIGNED(1'b1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    lsu_align #(.ADDR_W(12), .ALLOW_MISALIGNED(1'b0)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

    // ------------------------------------------------------------------
    // RAM models: combinational read, write at posedge
    // ------------------------------------------------------------------
    logic [7:0] mem0 [4096];
    logic [7:0] mem1 [4096];

    function automatic logic [31:0] ram_rd(input logic [2:0] m, input logic [7:0] b0, b1, b2, b3);
        if (m[1])      return {b3, b2, b1, b0};
        else if (m[0]) return m[2] ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
        else           return m[2] ? {24'h0, b0} : {{24{b0[7]}}, b0};
    endfunction

    logic [11:0] a0_1, a0_2, a0_3, a1_1, a1_2, a1_3;
    assign a0_1 = bus0.ram_addr + 12'd1;
    assign a0_2 = bus0.ram_addr + 12'd2;
    assign a0_3 = bus0.ram_addr + 12'd3;
    assign a1_1 = bus1.ram_addr + 12'd1;
    assign a1_2 = bus1.ram_addr + 12'd2;
    assign a1_3 = bus1.ram_addr + 12'd3;

    assign bus0.ram_dout = ram_rd(bus0.ram_mode, mem0[bus0.ram_addr], mem0[a0_1], mem0[a0_2], mem0[a0_3]);
    assign bus1.ram_dout = ram_rd(bus1.ram_mode, mem1[bus1.ram_addr], mem1[a1_1], mem1[a1_2], mem1[a1_3]);

    always @(posedge clk) begin
        if (bus0.ram_we) begin
            mem0[bus0.ram_addr] <= bus0.ram_din[7:0];
            if (bus0.ram_mode[1] | bus0.ram_mode[0]) mem0[a0_1] <= bus0.ram_din[15:8];
            if (bus0.ram_mode[1]) begin
                mem0[a0_2] <= bus0.ram_din[23:16];
                mem0[a0_3] <= bus0.ram_din[31:24];
            end
        end
        if (bus1.ram_we) begin
            mem1[bus1.ram_addr] <= bus1.ram_din[7:0];
            if (bus1.ram_mode[1] | bus1.ram_mode[0]) mem1[a1_1] <= bus1.ram_din[15:8];
            if (bus1.ram_mode[1]) begin
                mem1[a1_2] <= bus1.ram_din[23:16];
                mem1[a1_3] <= bus1.ram_din[31:24];
            end
        end
    end

    // ------------------------------------------------------------------
    // Drivers: one call = one clock cycle; outputs settled on return
    // ------------------------------------------------------------------
    task automatic drive0(input logic v, input logic we, input logic [2:0] f3,
                          input logic [11:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus0.req_valid = v; bus0.req_we = we; bus0.req_funct3 = f3;
        bus0.req_addr = a; bus0.req_wdata = wd;
        #1;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [2:0] f3,
                          input logic [11:0] a, input logic [31:0] wd);
        @(negedge clk);
        bus1.req_valid = v; bus1.req_we = we; bus1.req_funct3 = f3;
        bus1.req_addr = a; bus1.req_wdata = wd;
        #1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
        rst = 1'b0;
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
        n_cmp++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b want 0", bus0.stall); end
        n_cmp++; if (bus0.ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we: got %0b want 0", bus0.ram_we); end
        n_cmp++; if (bus0.rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", bus0.rdata); end
        n_cmp++; if (bus1.misalign_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b want 0", bus1.misalign_err); end
    endtask

    task automatic test_aligned();
        drive0(1'b1, 1'b1, 3'b010, 12'h010, 32'hDEADBEEF);
        n_cmp++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL al_sw_stall: got %0b want 0", bus0.stall); end
        n_cmp++; if (bus0.ram_we !== 1'b1) begin n_err++; $display("FAIL al_sw_we: got %0b want 1", bus0.ram_we); end
        drive0(1'b1, 1'b0, 3'b010, 12'h010, 32'h0);
        n_cmp++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL al_lw_stall: got %0b want 0", bus0.stall); end
        n_cmp++; if (bus0.rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL al_lw_rdata: got %h want deadbeef", bus0.rdata); end
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
        n_cmp++; if (bus0.rdata !== 32'h0) begin n_err++; $display("FAIL idle_rdata: got %h want 0", bus0.rdata); end
    endtask

    task automatic test_mis_lw();
        drive0(1'b1, 1'b1, 3'b010, 12'h010, 32'h44332211);
        drive0(1'b1, 1'b1, 3'b010, 12'h014, 32'h88776655);
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 1'b0, 3'b010, 12'h011, 32'h0);
            n_cmp++; if (bus0.stall !== (i < 3)) begin n_err++; $display("FAIL mlw_stall[%0d]: got %0b want %0b", i, bus0.stall, (i < 3)); end
            n_cmp++; if (bus0.ram_addr !== 12'h011 + 12'(i)) begin n_err++; $display("FAIL mlw_addr[%0d]: got %h want %h", i, bus0.ram_addr, 12'h011 + 12'(i)); end
            n_cmp++; if (bus0.ram_mode !== 3'b100) begin n_err++; $display("FAIL mlw_mode[%0d]: got %b want 100", i, bus0.ram_mode); end
            n_cmp++; if (bus0.ram_we !== 1'b0) begin n_err++; $display("FAIL mlw_we[%0d]: got %0b want 0", i, bus0.ram_we); end
        end
        n_cmp++; if (bus0.rdata !== 32'h55443322) begin n_err++; $display("FAIL mlw_rdata: got %h want 55443322", bus0.rdata); end
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
        n_cmp++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL mlw_after_stall: got %0b want 0", bus0.stall); end
    endtask

    task automatic test_mis_lh();
        // [0x014]=0x88776655 already, so byte 0x017 = 0x88
        drive0(1'b1, 1'b1, 3'b010, 12'h018, 32'h000000FF);
        drive0(1'b1, 1'b0, 3'b001, 12'h017, 32'h0);
        n_cmp++; if (bus0.stall !== 1'b1) begin n_err++; $display("FAIL mlh_stall0: got %0b want 1", bus0.stall); end
        drive0(1'b1, 1'b0, 3'b001, 12'h017, 32'h0);
        n_cmp++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL mlh_stall1: got %0b want 0", bus0.stall); end
        n_cmp++; if (bus0.rdata !== 32'hFFFFFF88) begin n_err++; $display("FAIL mlh_rdata: got %h want ffffff88", bus0.rdata); end
        drive0(1'b1, 1'b0, 3'b101, 12'h017, 32'h0);
        drive0(1'b1, 1'b0, 3'b101, 12'h017, 32'h0);
        n_cmp++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL mlhu_stall1: got %0b want 0", bus0.stall); end
        n_cmp++; if (bus0.rdata !== 32'h0000FF88) begin n_err++; $display("FAIL mlhu_rdata: got %h want 0000ff88", bus0.rdata); end
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
    endtask

    task automatic test_mis_sw();
        logic [7:0] eb [4];
        eb = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
        drive0(1'b1, 1'b1, 3'b010, 12'h00C, 32'h0);
        drive0(1'b1, 1'b1, 3'b010, 12'h010, 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 1'b1, 3'b010, 12'h00E, 32'hA1B2C3D4);
            n_cmp++; if (bus0.ram_we !== 1'b1) begin n_err++; $display("FAIL msw_we[%0d]: got %0b want 1", i, bus0.ram_we); end
            n_cmp++; if (bus0.ram_addr !== 12'h00E + 12'(i)) begin n_err++; $display("FAIL msw_addr[%0d]: got %h want %h", i, bus0.ram_addr, 12'h00E + 12'(i)); end
            n_cmp++; if (bus0.ram_din[7:0] !== eb[i]) begin n_err++; $display("FAIL msw_din[%0d]: got %h want %h", i, bus0.ram_din[7:0], eb[i]); end
            n_cmp++; if (bus0.ram_mode !== 3'b000) begin n_err++; $display("FAIL msw_mode[%0d]: got %b want 000", i, bus0.ram_mode); end
            n_cmp++; if (bus0.stall !== (i < 3)) begin n_err++; $display("FAIL msw_stall[%0d]: got %0b want %0b", i, bus0.stall, (i < 3)); end
        end
        drive0(1'b1, 1'b0, 3'b010, 12'h00C, 32'h0);
        n_cmp++; if (bus0.rdata !== 32'hC3D40000) begin n_err++; $display("FAIL msw_rd0c: got %h want c3d40000", bus0.rdata); end
        drive0(1'b1, 1'b0, 3'b010, 12'h010, 32'h0);
        n_cmp++; if (bus0.rdata !== 32'h0000A1B2) begin n_err++; $display("FAIL msw_rd10: got %h want 0000a1b2", bus0.rdata); end
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
    endtask

    task automatic test_reset_busy();
        drive0(1'b1, 1'b1, 3'b010, 12'h00C, 32'h0);
        drive0(1'b1, 1'b1, 3'b010, 12'h010, 32'h0);
        drive0(1'b1, 1'b1, 3'b010, 12'h00E, 32'hA1B2C3D4);
        drive0(1'b1, 1'b1, 3'b010, 12'h00E, 32'hA1B2C3D4);
        drive0(1'b1, 1'b1, 3'b010, 12'h00E, 32'hA1B2C3D4);
        rst = 1'b1;
        #1;
        n_cmp++; if (bus0.ram_we !== 1'b0) begin n_err++; $display("FAIL rb_we_in_rst: got %0b want 0", bus0.ram_we); end
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
        rst = 1'b0;
        n_cmp++; if (bus0.stall !== 1'b0) begin n_err++; $display("FAIL rb_stall: got %0b want 0", bus0.stall); end
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
        n_cmp++; if (bus0.ram_we !== 1'b0) begin n_err++; $display("FAIL rb_idle_we: got %0b want 0", bus0.ram_we); end
        drive0(1'b1, 1'b0, 3'b010, 12'h00C, 32'h0);
        n_cmp++; if (bus0.rdata !== 32'hC3D40000) begin n_err++; $display("FAIL rb_rd0c: got %h want c3d40000", bus0.rdata); end
        drive0(1'b1, 1'b0, 3'b010, 12'h010, 32'h0);
        n_cmp++; if (bus0.rdata !== 32'h00000000) begin n_err++; $display("FAIL rb_rd10: got %h want 00000000", bus0.rdata); end
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
    endtask

    task automatic test_wrap();
        logic [11:0] ea [4];
        ea = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        drive0(1'b1, 1'b1, 3'b010, 12'hFFC, 32'h12345678);
        drive0(1'b1, 1'b1, 3'b010, 12'h000, 32'hCAFEBABE);
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, 1'b0, 3'b010, 12'hFFE, 32'h0);
            n_cmp++; if (bus0.ram_addr !== ea[i]) begin n_err++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, bus0.ram_addr, ea[i]); end
        end
        n_cmp++; if (bus0.rdata !== 32'hBABE1234) begin n_err++; $display("FAIL wrap_rdata: got %h want babe1234", bus0.rdata); end
        drive0(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
    endtask

    task automatic test_misalign_err();
        drive1(1'b1, 1'b1, 3'b010, 12'h000, 32'h0);
        drive1(1'b1, 1'b1, 3'b010, 12'h002, 32'hFFFFFFFF);
        n_cmp++; if (bus1.misalign_err !== 1'b1) begin n_err++; $display("FAIL err_sw_flag: got %0b want 1", bus1.misalign_err); end
        n_cmp++; if (bus1.ram_we !== 1'b0) begin n_err++; $display("FAIL err_sw_we: got %0b want 0", bus1.ram_we); end
        n_cmp++; if (bus1.stall !== 1'b0) begin n_err++; $display("FAIL err_sw_stall: got %0b want 0", bus1.stall); end
        drive1(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
        n_cmp++; if (bus1.misalign_err !== 1'b0) begin n_err++; $display("FAIL err_pulse: got %0b want 0", bus1.misalign_err); end
        drive1(1'b1, 1'b0, 3'b001, 12'h001, 32'h0);
        n_cmp++; if (bus1.misalign_err !== 1'b1) begin n_err++; $display("FAIL err_lh_flag: got %0b want 1", bus1.misalign_err); end
        n_cmp++; if (bus1.rdata !== 32'h0) begin n_err++; $display("FAIL err_lh_rdata: got %h want 0", bus1.rdata); end
        // bytes are never misaligned
        drive1(1'b1, 1'b1, 3'b000, 12'h003, 32'h0000005A);
        n_cmp++; if (bus1.misalign_err !== 1'b0) begin n_err++; $display("FAIL err_sb_flag: got %0b want 0", bus1.misalign_err); end
        n_cmp++; if (bus1.ram_we !== 1'b1) begin n_err++; $display("FAIL err_sb_we: got %0b want 1", bus1.ram_we); end
        drive1(1'b1, 1'b0, 3'b010, 12'h000, 32'h0);
        n_cmp++; if (bus1.rdata !== 32'h5A000000) begin n_err++; $display("FAIL err_rd00: got %h want 5a000000", bus1.rdata); end
        drive1(1'b0, 1'b0, 3'b010, 12'h000, 32'h0);
    endtask

    initial begin
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = 3'b010;
        bus0.req_addr = 12'h000; bus0.req_wdata = 32'h0;
        bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = 3'b010;
        bus1.req_addr = 12'h000; bus1.req_wdata = 32'h0;
        test_reset();
        test_aligned();
        test_mis_lw();
        test_mis_lh();
        test_mis_sw();
        test_reset_busy();
        test_wrap();
        test_misalign_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lsu_align.md
Name: lsu_align

Overview:
- Load/store front end between the MEM pipeline stage and the byte/half/word data RAM.
- Aligned accesses pass straight through to the RAM in the same cycle.
- Misaligned halfword/word accesses are split into sequential byte accesses, with a pipeline stall while they run. Loads are reassembled little-endian and sign- or zero-extended.
- Drives the RAM port (we, mode, addr, din) and consumes its combinational read data.

Parameters:
- ADDR_W, 12, byte-address width (RAM SIZE + 2).
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses; 0 = flag misaligned accesses as an error and suppress them.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  memory request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data
- stall  out  1  hold pipeline; the request is not complete this cycle
- rdata  out  32  load result; valid in the cycle req_valid && !req_we && !stall
- misalign_err  out  1  one-cycle pulse (ALLOW_MISALIGNED=0 only)
- ram_we  out  1  RAM write enable
- ram_mode  out  3  RAM access mode (funct3 encoding)
- ram_addr  out  ADDR_W  RAM byte address
- ram_din  out  32  RAM write data
- ram_dout  in  32  RAM combinational read data

Behaviour:
- Misaligned definition:
  - funct3[1:0]=01 and addr[0]=1, or
  - funct3[1]=1 and addr[1:0]!=0.
  - Bytes are never misaligned. Codes 011/110/111 are treated as word.
- Byte count N: 2 for half, 4 for word.
- States: IDLE, BUSY. Byte index idx is 2 bits. lbuf is 24 bits of assembled load bytes.
- Reset: state=IDLE, idx=0, lbuf=0, misalign_err=0. With no request pending, stall=0 and ram_we=0.
- IDLE, no valid request: ram_we=0; ram_mode/addr/din follow the req inputs.
- IDLE, valid and aligned:
  - ram_we=req_we, ram_mode=req_funct3, ram_addr=req_addr, ram_din=req_wdata.
  - rdata=ram_dout, stall=0. Latency 0 (store commits at this edge).
- IDLE, valid and misaligned, ALLOW_MISALIGNED=1:
  - Capture addr, funct3, we, wdata.
  - Issue byte 0 this cycle: ram_mode=100 for loads, 000 for stores; ram_addr=addr; ram_din[7:0]=wdata[7:0].
  - Set stall=1; load lbuf[7:0]=ram_dout[7:0]; set idx=1; go to BUSY.
- BUSY: uses captured values only (req inputs ignored).
  - Issue byte idx at address addr+idx, wrapping modulo 2^ADDR_W. ram_din[7:0]=wdata byte idx.
  - If idx<N-1: stall=1, lbuf byte idx=ram_dout[7:0], idx++.
  - If idx=N-1: stall=0 and rdata formed combinationally:
    - value = {ram_dout[7:0], lbuf} for word, {ram_dout[7:0], lbuf[7:0]} for half.
    - Sign-extend if funct3[2]=0, else zero-extend.
    - Return to IDLE with idx=0.
- Totals: misaligned half takes 2 cycles (1 stall); misaligned word takes 4 cycles (3 stall).
- Store bytes commit at the clock edge ending each byte's cycle, in ascending address order.
- ALLOW_MISALIGNED=0, misaligned request: ram_we=0, stall=0, rdata=0, misalign_err=1 for that cycle; stay IDLE.
- rst while BUSY: IDLE next cycle, stall=0. Bytes already written remain; remaining bytes are never issued.
- rdata when not valid: 0.

Decomposition:
- lsu_pkg holds:
  - state enum {IDLE, BUSY}.
  - funct3 constants F3_B/H/W/BU/HU.
  - functions is_misaligned(funct3, addr[1:0]), nbytes(funct3), and load_extend(raw32, funct3).
- No sub-module: single module plus package.

Test Plan:
- Aligned: sw 0xDEADBEEF @0x010, then lw @0x010 -> stall=0 both cycles; rdata=0xDEADBEEF in the load cycle.
- Misaligned lw: preload [0x010]=0x44332211, [0x014]=0x88776655; lw @0x011 -> stall=1,1,1,0; RAM addrs 0x011..0x014; rdata=0x55443322 on the 4th cycle.
- Misaligned lh/lhu @0x017 with [0x018]=0x000000FF:
  - lh -> 1 stall cycle, rdata=0xFFFFFF88.
  - lhu -> rdata=0x0000FF88.
- Misaligned sw 0xA1B2C3D4 @0x00E over zeroed RAM -> 4 byte writes; then lw @0x00C=0xC3D40000 and lw @0x010=0x0000A1B2.
- rst asserted in BUSY after 2 bytes of sw 0xA1B2C3D4 @0x00E -> stall=0 next cycle; [0x00C]=0xC3D40000, [0x010]=0x00000000.
- Wrap and error cases:
  - lw @0xFFE -> bytes from 0xFFE, 0xFFF, 0x000, 0x001.
  - ALLOW_MISALIGNED=0, sw @0x002 -> misalign_err one cycle, no RAM write, stall=0.
